load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 ls_valid_i  input  1  core presents a load/store; core holds all ls_* inputs stable while stall_o=1.
REQ-004 ls_write_i  input  1  1=store, 0=load.
REQ-005 ls_funct3_i  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 ls_addr_i  input  32  byte address (ALU result).
REQ-007 ls_wdata_i  input  32  store data (rs2).
REQ-008 stall_o  output  1  core must hold the current instruction.
REQ-009 done_o  output  1  one-cycle pulse: access complete.
REQ-010 misaligned_o  output  1  one-cycle pulse with done_o: access rejected.
REQ-011 rdata_o  output  32  extended load result, feeding write-back data_mem_out.
REQ-012 mem_req_valid_o / mem_req_ready_i  out/in  1/1  request handshake; transfer when both are 1.
REQ-013 mem_we_o  output  1  write request.
REQ-014 mem_addr_o  output  32  word address, bits[1:0]=00.
REQ-015 mem_wdata_o, mem_wstrb_o  output  32, 4  lane-positioned store data and byte strobes.
REQ-016 mem_rsp_valid_i, mem_rdata_i  input  1, 32  load response word.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, RSP and DONE.
REQ-018 IDLE, ls_valid_i=1, aligned: capture op/addr/data, go to REQ, stall_o=1 the same cycle (combinational).
REQ-019 IDLE, ls_valid_i=1, misaligned: go to DONE with misaligned flag set, no bus traffic, rdata_o unchanged.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=00.
REQ-020 REQ: mem_req_valid_o=1 from captured registers, held until mem_req_ready_i=1; the request fields SHALL NOT change while valid is high.
REQ-021 REQ handshake: store goes to DONE; load goes to RSP.
REQ-022 RSP: wait indefinitely for mem_rsp_valid_i; when it is 1, register the extended result into rdata_o and go to DONE.
REQ-023 DONE: done_o=1, stall_o=0, misaligned_o = captured flag, new requests ignored; next state is IDLE.
REQ-024 stall_o SHALL be 1 in REQ and RSP, and in IDLE when an access is accepted; 0 otherwise.
REQ-025 Best-case latency: load 3 stall cycles (IDLE, REQ, RSP) then DONE; store 2 stall cycles then DONE.
REQ-026 Store lanes:
  - SB: byte replicated to all 4 lanes, wstrb = 1<<addr[1:0].
  - SH: half replicated, wstrb 0011 (addr[1]=0) or 1100.
  - SW: wstrb 1111.
  - Loads: mem_we_o=0, wstrb 0000.
REQ-027 Load extract: select byte addr[1:0] or half addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through.
REQ-028 Undefined funct3 (011, 110, 111) SHALL be treated as word access.
REQ-029 mem_rsp_valid_i outside RSP SHALL be ignored.
REQ-030 rdata_o SHALL hold its value until the next successful load.

Reset
REQ-031 On rst_n=0, immediately: state IDLE, rdata_o=0, captured regs 0.
  - All outputs 0: stall_o, done_o, misaligned_o, mem_req_valid_o, mem_we_o, mem_wstrb_o, mem_addr_o, mem_wdata_o.
REQ-032 Reset mid-transaction SHALL drop mem_req_valid_o asynchronously; a late response after reset is ignored.

Structure
REQ-033 Shared package rv32_pkg SHALL hold funct3 load/store constants and the FSM state encoding.
REQ-034 A combinational sub-module load_extend SHALL perform lane selection and sign/zero extension.

Verification
REQ-035 LB addr 0x1003, rsp 0x80FF_FF11, ready=1 immediately -> rdata_o=0xFFFF_FF80; done_o in the 4th cycle.
REQ-036 SH addr 0x2002, wdata 0x0000_BEEF -> mem_addr_o=0x2000, wdata 0xBEEF_BEEF, wstrb 1100, we=1.
REQ-037 LW addr 0x3001 -> no mem_req_valid_o, misaligned_o=done_o=1 next cycle, rdata_o unchanged.
REQ-038 LHU addr 0x4002, ready held low 5 cycles, rsp 2 cycles later with 0x8001_0000 -> request stable throughout, rdata_o=0x0000_8001.
REQ-039 rst_n low during RSP, then a rsp pulse -> outputs 0 at once, rdata_o stays 0, state IDLE.
REQ-040 Back-to-back SW then LBU with ls_valid_i held -> exactly one request per instruction; second accepted the cycle after DONE.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 load/store definitions: funct3 encodings, access sizes,
// the load/store FSM state encoding and small decode helpers.
package rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } lsuState_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } accessSize_t;

    // Undefined funct3 codes fall through to a full word access.
    function automatic accessSize_t accessSize(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (accessSize(funct3))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            default: return (offset != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a returned memory word and
// sign- or zero-extends it to 32 bits according to funct3.
module load_extend
    import rv32_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection by the low address bits.
    always_comb begin
        w_byte = i_word[7:0];
        case (i_offset)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    // Extension; anything that is not a byte/half access passes the word through.
    always_comb begin
        o_data = i_word;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core access at a time, issues a single
// word-aligned bus request, waits for load data and reports completion.
module load_store_unit
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ls_valid_i,
    input  logic        ls_write_i,
    input  logic [2:0]  ls_funct3_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        misaligned_o,
    output logic [31:0] rdata_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rdata_i
);

    lsuState_t   r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_misal;
    logic [31:0] r_rdata;

    logic        w_misal;
    logic        w_accept;
    logic [31:0] w_laneData;
    logic [3:0]  w_laneStrb;
    logic [31:0] w_extData;

    assign w_misal  = isMisaligned(ls_funct3_i, ls_addr_i[1:0]);
    // rst_n gates acceptance so stall_o reads 0 while reset is asserted.
    assign w_accept = rst_n && (r_state == ST_IDLE) && ls_valid_i && !w_misal;

    // Position store data on the byte lanes and build the matching strobes.
    always_comb begin
        w_laneData = ls_wdata_i;
        w_laneStrb = 4'b1111;
        case (accessSize(ls_funct3_i))
            SZ_BYTE: begin
                w_laneData = {4{ls_wdata_i[7:0]}};
                w_laneStrb = 4'b0001 << ls_addr_i[1:0];
            end
            SZ_HALF: begin
                w_laneData = {2{ls_wdata_i[15:0]}};
                w_laneStrb = ls_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_laneData = ls_wdata_i;
                w_laneStrb = 4'b1111;
            end
        endcase
    end

    load_extend u_loadExtend (
        .i_word   (mem_rdata_i),
        .i_funct3 (r_funct3),
        .i_offset (r_addr[1:0]),
        .o_data   (w_extData)
    );

    // Access sequencer: capture in IDLE, hold the request in REQ, wait for data in RSP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
            r_misal  <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ls_valid_i) begin
                        if (w_misal) begin
                            r_misal <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_misal  <= 1'b0;
                            r_we     <= ls_write_i;
                            r_funct3 <= ls_funct3_i;
                            r_addr   <= ls_addr_i;
                            r_wdata  <= w_laneData;
                            r_wstrb  <= ls_write_i ? w_laneStrb : 4'b0000;
                            r_state  <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready_i) begin
                        r_state <= r_we ? ST_DONE : ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (mem_rsp_valid_i) begin
                        r_rdata <= w_extData;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign stall_o         = (r_state == ST_REQ) || (r_state == ST_RSP) || w_accept;
    assign done_o          = (r_state == ST_DONE);
    assign misaligned_o    = (r_state == ST_DONE) && r_misal;
    assign rdata_o         = r_rdata;
    assign mem_req_valid_o = (r_state == ST_REQ);
    assign mem_we_o        = r_we;
    assign mem_addr_o      = {r_addr[31:2], 2'b00};
    assign mem_wdata_o     = r_wdata;
    assign mem_wstrb_o     = r_wstrb;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus
// randomized accesses checked against a byte-level reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ls_valid_i;
    logic        ls_write_i;
    logic [2:0]  ls_funct3_i;
    logic [31:0] ls_addr_i;
    logic [31:0] ls_wdata_i;
    logic        stall_o;
    logic        done_o;
    logic        misaligned_o;
    logic [31:0] rdata_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rdata_i;

    int testsRun    = 0;
    int testsFailed = 0;
    int hsCount     = 0;
    logic [31:0] rdataModel = 32'd0;

    load_store_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ls_valid_i      (ls_valid_i),
        .ls_write_i      (ls_write_i),
        .ls_funct3_i     (ls_funct3_i),
        .ls_addr_i       (ls_addr_i),
        .ls_wdata_i      (ls_wdata_i),
        .stall_o         (stall_o),
        .done_o          (done_o),
        .misaligned_o    (misaligned_o),
        .rdata_o         (rdata_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_wstrb_o     (mem_wstrb_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rdata_i     (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Count bus transfers so each instruction can be shown to issue exactly one.
    always @(posedge clk) begin
        if (mem_req_valid_o && mem_req_ready_i) hsCount = hsCount + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int sizeOf(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_stall"}, 32'(stall_o), 32'd0);
        checkOutput({tag, "_done"}, 32'(done_o), 32'd0);
        checkOutput({tag, "_misal"}, 32'(misaligned_o), 32'd0);
        checkOutput({tag, "_reqValid"}, 32'(mem_req_valid_o), 32'd0);
        checkOutput({tag, "_we"}, 32'(mem_we_o), 32'd0);
        checkOutput({tag, "_strb"}, 32'(mem_wstrb_o), 32'd0);
        checkOutput({tag, "_addr"}, mem_addr_o, 32'd0);
        checkOutput({tag, "_wdata"}, mem_wdata_o, 32'd0);
        checkOutput({tag, "_rdata"}, rdata_o, 32'd0);
    endtask

    // Runs one core access end to end and checks every cycle against the model.
    task automatic applyStimulus(input logic write, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int readyDelay, input int rspDelay,
                                 input logic [31:0] rspWord, input bit holdValid);
        int size;
        int offs;
        bit mis;
        int startHs;
        logic [31:0] expWdata;
        logic [3:0]  expStrb;
        logic [31:0] expRdata;
        logic [31:0] mask;
        size = sizeOf(f3);
        offs = int'(addr[1:0]);
        mis  = (offs % size) != 0;
        for (int k = 0; k < 4; k++) expWdata[8*k +: 8] = wdata[8*(k % size) +: 8];
        expStrb  = write ? 4'(((1 << size) - 1) << offs) : 4'b0000;
        mask     = (size == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8*size)) - 64'd1);
        expRdata = (rspWord >> (8*offs)) & mask;
        if ((f3 == 3'b000 || f3 == 3'b001) && expRdata[8*size-1]) expRdata = expRdata | ~mask;

        @(negedge clk);
        ls_valid_i  = 1'b1;
        ls_write_i  = write;
        ls_funct3_i = f3;
        ls_addr_i   = addr;
        ls_wdata_i  = wdata;
        startHs     = hsCount;
        #1;
        checkOutput("stallAccept", 32'(stall_o), 32'(!mis));
        checkOutput("idleNoReq", 32'(mem_req_valid_o), 32'd0);
        @(negedge clk);
        if (!mis) begin
            for (int c = 0; c <= readyDelay; c++) begin
                checkOutput("reqValid", 32'(mem_req_valid_o), 32'd1);
                checkOutput("reqStall", 32'(stall_o), 32'd1);
                checkOutput("reqAddr", mem_addr_o, addr & 32'hFFFF_FFFC);
                checkOutput("reqWe", 32'(mem_we_o), 32'(write));
                checkOutput("reqStrb", 32'(mem_wstrb_o), 32'(expStrb));
                if (write) checkOutput("reqWdata", mem_wdata_o, expWdata);
                mem_req_ready_i = (c == readyDelay);
                @(negedge clk);
            end
            mem_req_ready_i = 1'b0;
            if (!write) begin
                for (int c = 0; c < rspDelay; c++) begin
                    checkOutput("rspStall", 32'(stall_o), 32'd1);
                    checkOutput("rspNoReq", 32'(mem_req_valid_o), 32'd0);
                    @(negedge clk);
                end
                mem_rsp_valid_i = 1'b1;
                mem_rdata_i     = rspWord;
                @(negedge clk);
                mem_rsp_valid_i = 1'b0;
                rdataModel      = expRdata;
            end
        end
        checkOutput("doneDone", 32'(done_o), 32'd1);
        checkOutput("doneMisal", 32'(misaligned_o), 32'(mis));
        checkOutput("doneStall", 32'(stall_o), 32'd0);
        checkOutput("doneNoReq", 32'(mem_req_valid_o), 32'd0);
        checkOutput("doneRdata", rdata_o, rdataModel);
        checkOutput("doneHsCount", 32'(hsCount - startHs), mis ? 32'd0 : 32'd1);
        if (!holdValid) begin
            ls_valid_i      = 1'b0;
            mem_rsp_valid_i = 1'b1;
            mem_rdata_i     = $urandom;
            @(negedge clk);
            mem_rsp_valid_i = 1'b0;
            checkOutput("afterDone", 32'(done_o), 32'd0);
            checkOutput("afterStall", 32'(stall_o), 32'd0);
            checkOutput("strayRspIgnored", rdata_o, rdataModel);
        end
    endtask

    // Asserts reset while a load is outstanding, then offers a late response.
    task automatic resetMidTransaction(input bit inRsp);
        @(negedge clk);
        ls_valid_i  = 1'b1;
        ls_write_i  = 1'b0;
        ls_funct3_i = 3'b000;
        ls_addr_i   = 32'h0000_6001;
        @(negedge clk);
        checkOutput("preResetReq", 32'(mem_req_valid_o), 32'd1);
        mem_req_ready_i = inRsp;
        if (inRsp) begin
            @(negedge clk);
            mem_req_ready_i = 1'b0;
            checkOutput("preResetRsp", 32'(stall_o), 32'd1);
        end
        ls_valid_i = 1'b0;
        #1 rst_n = 1'b0;
        #1 checkAllZero(inRsp ? "rstInRsp" : "rstInReq");
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        rdataModel = 32'd0;
        checkOutput("lateRspRdata", rdata_o, 32'd0);
        checkOutput("lateRspDone", 32'(done_o), 32'd0);
        checkOutput("lateRspReq", 32'(mem_req_valid_o), 32'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        ls_valid_i      = 1'b1;
        ls_write_i      = 1'b0;
        ls_funct3_i     = 3'b010;
        ls_addr_i       = 32'd0;
        ls_wdata_i      = 32'd0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i     = 32'd0;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        ls_valid_i = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 3'b000, 32'h0000_1003, 32'd0, 0, 0, 32'h80FF_FF11, 1'b0);
        checkOutput("lbResult", rdata_o, 32'hFFFF_FF80);
        applyStimulus(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 0, 0, 32'd0, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h0000_3001, 32'd0, 0, 0, 32'd0, 1'b0);
        applyStimulus(1'b0, 3'b101, 32'h0000_4002, 32'd0, 5, 2, 32'h8001_0000, 1'b0);
        checkOutput("lhuResult", rdata_o, 32'h0000_8001);

        resetMidTransaction(1'b0);
        applyStimulus(1'b0, 3'b010, 32'h0000_7000, 32'd0, 1, 1, 32'h1234_5678, 1'b0);
        resetMidTransaction(1'b1);

        applyStimulus(1'b1, 3'b010, 32'h0000_5000, 32'h1234_5678, 0, 0, 32'd0, 1'b1);
        applyStimulus(1'b0, 3'b100, 32'h0000_5001, 32'd0, 0, 0, 32'hAABB_CCDD, 1'b0);
        checkOutput("lbuResult", rdata_o, 32'h0000_00CC);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                          ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        ls_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
